tcb_vip_sub_memory: RTL and testbench



---
 rtl/tcb_vip_sub_memory.sv | 204 ++++++++++++++++++++
 tb/tb_tcb_vip_sub_memory.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_vip_sub_memory.sv
// tcb_vip_sub_memory
//   Active TCB subordinate used as the target memory in benches. Requests are
//   accepted on vld & rdy, write data lands in an internal byte-lane array,
//   and read data / error status return through a fixed-depth response
//   pipeline. A reload-on-transfer stall counter provides deterministic
//   back-pressure so that manager stall handling gets exercised.
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   vld      request valid from the manager
//   rdy      request ready (registered, never depends on vld)
//   req_wen  1 = write, 0 = read
//   req_adr  byte address (ABW bits)
//   req_ben  byte enables (DBW/8 bits)
//   req_wdt  write data
//   rsp_rdt  read data, held between read responses
//   rsp_err  error response (address outside the array), held between responses

module tcb_vip_sub_memory #(
    parameter int unsigned ABW    = 32,
    parameter int unsigned DBW    = 32,
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned DLY    = 1,
    parameter int unsigned STALL  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    output logic               rdy,
    input  logic               req_wen,
    input  logic [ABW-1:0]     req_adr,
    input  logic [DBW/8-1:0]   req_ben,
    input  logic [DBW-1:0]     req_wdt,
    output logic [DBW-1:0]     rsp_rdt,
    output logic               rsp_err
);

    localparam int unsigned BEW   = DBW / 8;
    localparam int unsigned OFF   = $clog2(BEW);
    localparam int unsigned WAW   = (MEM_AW > OFF) ? (MEM_AW - OFF) : 0;
    localparam int unsigned IW    = (WAW > 0) ? WAW : 1;
    localparam int unsigned WORDS = 2 ** WAW;
    localparam int unsigned CW    = (STALL > 0) ? $clog2(STALL + 1) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (!(DBW == 8 || DBW == 16 || DBW == 32 || DBW == 64)) begin : g_bad_dbw
            $fatal(1, "tcb_vip_sub_memory: DBW must be 8, 16, 32 or 64");
        end
        if (MEM_AW < OFF || MEM_AW > ABW) begin : g_bad_mem_aw
            $fatal(1, "tcb_vip_sub_memory: MEM_AW must lie in [log2(DBW/8), ABW]");
        end
        if (DLY > 4) begin : g_bad_dly
            $fatal(1, "tcb_vip_sub_memory: DLY must be 0..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and address decode
    // ------------------------------------------------------------------
    logic          xfer;
    logic          oor;
    logic [IW-1:0] widx;

    // Gating with rst keeps the DLY=0 outputs and the array quiet while
    // reset is held.
    assign xfer = vld & rdy & ~rst;

    generate
        if (MEM_AW < ABW) begin : g_oor
            assign oor = |req_adr[ABW-1:MEM_AW];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end

        if (WAW > 0) begin : g_widx
            assign widx = req_adr[MEM_AW-1:OFF];
        end else begin : g_widx0
            assign widx = '0;
        end

        // Sub-word address bits select nothing; lanes come from req_ben.
        if (OFF > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^req_adr[OFF-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: one word per entry, byte lane i = byte address word*BEW+i.
    // Contents are deliberately not reset.
    // ------------------------------------------------------------------
    logic [DBW-1:0] mem [WORDS];
    logic [DBW-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (xfer && req_wen && !oor) begin
            for (int unsigned i = 0; i < BEW; i++) begin
                if (req_ben[i]) begin
                    mem[widx][i*8 +: 8] <= req_wdt[i*8 +: 8];
                end
            end
        end
    end

    // Read samples the array as it stands before the transfer edge.
    assign rd_data = oor ? '0 : mem[widx];

    // ------------------------------------------------------------------
    // Back-pressure: counter reloads on every transfer, rdy is a flop
    // tracking (counter == 0) of the next state.
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (xfer) begin
            cnt_nxt = CW'(STALL);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rdy <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            rdy <= (cnt_nxt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    typedef struct packed {
        logic           vld;
        logic           wen;
        logic           err;
        logic [DBW-1:0] rdt;
    } stage_t;

    stage_t cur;
    stage_t out;

    always_comb begin
        cur     = '0;
        cur.vld = xfer;
        cur.wen = req_wen;
        cur.err = oor;
        cur.rdt = rd_data;
    end

    generate
        if (DLY == 0) begin : g_dly0
            assign out = cur;
        end else begin : g_pipe
            stage_t pipe [DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DLY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= cur;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign out = pipe[DLY-1];
        end
    endgenerate

    // Outputs follow the output stage while it is valid and otherwise show
    // the value captured from the last valid response.
    logic           hold_err;
    logic [DBW-1:0] hold_rdt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_err <= 1'b0;
            hold_rdt <= '0;
        end else begin
            if (out.vld) begin
                hold_err <= out.err;
            end
            if (out.vld && !out.wen) begin
                hold_rdt <= out.rdt;
            end
        end
    end

    assign rsp_err = out.vld ? out.err : hold_err;
    assign rsp_rdt = (out.vld && !out.wen) ? out.rdt : hold_rdt;

endmodule

// File: tb/tb_tcb_vip_sub_memory.sv
// tb_tcb_vip_sub_memory
//   Directed bench for tcb_vip_sub_memory. Three instances share clk/rst:
//     inst 0 : DLY=1, STALL=0  (write/read, partial write, out of range)
//     inst 1 : DLY=2, STALL=2  (back-pressure, reset mid-flight)
//     inst 2 : DLY=3, STALL=0  (pipelined back-to-back reads)
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at the same point, after the edge has settled.

module tb_tcb_vip_sub_memory;

    logic        clk;
    logic        rst;
    logic        vld [3];
    logic        rdy [3];
    logic        wen [3];
    logic [31:0] adr [3];
    logic [3:0]  ben [3];
    logic [31:0] wdt [3];
    logic [31:0] rdt [3];
    logic        err [3];

    int asserts  = 0;
    int failures = 0;

    tcb_vip_sub_memory #(.ABW(32), .DBW(32), .MEM_AW(10), .DLY(1), .STALL(0)) u_mem0 (
        .clk(clk), .rst(rst), .vld(vld[0]), .rdy(rdy[0]), .req_wen(wen[0]),
        .req_adr(adr[0]), .req_ben(ben[0]), .req_wdt(wdt[0]),
        .rsp_rdt(rdt[0]), .rsp_err(err[0])
    );

    tcb_vip_sub_memory #(.ABW(32), .DBW(32), .MEM_AW(10), .DLY(2), .STALL(2)) u_mem1 (
        .clk(clk), .rst(rst), .vld(vld[1]), .rdy(rdy[1]), .req_wen(wen[1]),
        .req_adr(adr[1]), .req_ben(ben[1]), .req_wdt(wdt[1]),
        .rsp_rdt(rdt[1]), .rsp_err(err[1])
    );

    tcb_vip_sub_memory #(.ABW(32), .DBW(32), .MEM_AW(10), .DLY(3), .STALL(0)) u_mem2 (
        .clk(clk), .rst(rst), .vld(vld[2]), .rdy(rdy[2]), .req_wen(wen[2]),
        .req_adr(adr[2]), .req_ben(ben[2]), .req_wdt(wdt[2]),
        .rsp_rdt(rdt[2]), .rsp_err(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer on instance k; returns just after the transfer edge.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        int n;
        vld[k] = 1'b1; wen[k] = w; adr[k] = a; ben[k] = b; wdt[k] = d;
        n = 0;
        while (rdy[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            asserts++; failures++;
            $display("FAIL xfer_timeout: inst %0d rdy stuck at %b, required 1", k, rdy[k]);
        end
        step();
        vld[k] = 1'b0;
    endtask

    task automatic wait_rdy(input int k);
        int n;
        n = 0;
        while (rdy[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            asserts++; failures++;
            $display("FAIL wait_rdy_timeout: inst %0d rdy=%b, required 1", k, rdy[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; wen[k] = 1'b0; adr[k] = '0; ben[k] = '0; wdt[k] = '0;
        end
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            asserts++;
            if (rdy[k] !== 1'b1) begin
                failures++; $display("FAIL reset_rdy: inst %0d got %b required 1", k, rdy[k]);
            end
            asserts++;
            if (rdt[k] !== 32'h0) begin
                failures++; $display("FAIL reset_rdt: inst %0d got %h required 00000000", k, rdt[k]);
            end
            asserts++;
            if (err[k] !== 1'b0) begin
                failures++; $display("FAIL reset_err: inst %0d got %b required 0", k, err[k]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        asserts++;
        if (err[0] !== 1'b0) begin
            failures++; $display("FAIL wr_err: got %b required 0", err[0]);
        end
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_data: got %h required deadbeef", rdt[0]);
        end
        asserts++;
        if (err[0] !== 1'b0) begin
            failures++; $display("FAIL rd_err: got %b required 0", err[0]);
        end
        step();
        asserts++;
        if (rdt[0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_hold: got %h required deadbeef", rdt[0]);
        end
    endtask

    task automatic test_partial_write();
        xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        xfer(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        xfer(0, 1'b0, 32'h20, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'h11BB33DD) begin
            failures++; $display("FAIL partial_data: got %h required 11bb33dd", rdt[0]);
        end
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
        xfer(0, 1'b0, 32'h23, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'h11BB33DD) begin
            failures++; $display("FAIL low_bits_ignored: got %h required 11bb33dd", rdt[0]);
        end
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h12345678);
        xfer(0, 1'b1, 32'h400, 4'hF, 32'hBAD0BAD0);
        asserts++;
        if (err[0] !== 1'b1) begin
            failures++; $display("FAIL oor_wr_err: got %b required 1", err[0]);
        end
        xfer(0, 1'b0, 32'h400, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'h0) begin
            failures++; $display("FAIL oor_rd_data: got %h required 00000000", rdt[0]);
        end
        asserts++;
        if (err[0] !== 1'b1) begin
            failures++; $display("FAIL oor_rd_err: got %b required 1", err[0]);
        end
        xfer(0, 1'b0, 32'h0, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'h12345678) begin
            failures++; $display("FAIL oor_array_unchanged: got %h required 12345678", rdt[0]);
        end
        asserts++;
        if (err[0] !== 1'b0) begin
            failures++; $display("FAIL oor_err_clears: got %b required 0", err[0]);
        end
        xfer(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
        asserts++;
        if (err[0] !== 1'b1 || rdt[0] !== 32'h0) begin
            failures++; $display("FAIL oor_top_bit: got err=%b rdt=%h required err=1 rdt=00000000", err[0], rdt[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [5];
        exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd1; exp[3] = 32'd2; exp[4] = 32'd3;
        xfer(2, 1'b1, 32'h0, 4'hF, 32'd1);
        xfer(2, 1'b1, 32'h4, 4'hF, 32'd2);
        xfer(2, 1'b1, 32'h8, 4'hF, 32'd3);
        step(); step(); step();
        vld[2] = 1'b1; wen[2] = 1'b0; ben[2] = 4'h0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                adr[2] = 32'(4 * c);
                asserts++;
                if (rdy[2] !== 1'b1) begin
                    failures++; $display("FAIL b2b_rdy: cycle %0d got %b required 1", c, rdy[2]);
                end
            end else begin
                vld[2] = 1'b0;
            end
            step();
            if (c == 2) vld[2] = 1'b0;
            asserts++;
            if (rdt[2] !== exp[c]) begin
                failures++; $display("FAIL b2b_rdt: edge %0d got %h required %h", c, rdt[2], exp[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0]  pat;
        logic [31:0] expd;
        int          ntx;
        int          idx;
        pat = 10'b1001001001;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 32'(32'h40 + 4 * i), 4'hF, 32'(32'hA0 + i));
        end
        wait_rdy(1);
        ntx = 0;
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                asserts++;
                if (rdy[1] !== pat[c]) begin
                    failures++; $display("FAIL bp_rdy: cycle %0d got %b required %b", c, rdy[1], pat[c]);
                end
            end
            if (c < 2) begin
                expd = 32'h0;
            end else begin
                idx = (c - 2) / 3;
                if (idx > 3) idx = 3;
                expd = 32'(32'hA0 + idx);
            end
            asserts++;
            if (rdt[1] !== expd) begin
                failures++; $display("FAIL bp_rdt: cycle %0d got %h required %h", c, rdt[1], expd);
            end
            if (c < 10 && ntx < 4) begin
                vld[1] = 1'b1; wen[1] = 1'b0; ben[1] = 4'h0;
                adr[1] = 32'(32'h40 + 4 * ntx);
            end else begin
                vld[1] = 1'b0;
            end
            if (vld[1] === 1'b1 && rdy[1] === 1'b1) ntx++;
            step();
        end
        vld[1] = 1'b0;
        asserts++;
        if (ntx != 4) begin
            failures++; $display("FAIL bp_transfers: got %0d required 4", ntx);
        end
    endtask

    task automatic test_reset_midflight();
        wait_rdy(1);
        vld[1] = 1'b1; wen[1] = 1'b0; adr[1] = 32'h44; ben[1] = 4'h0;
        step();
        vld[1] = 1'b0;
        rst = 1'b1;
        #2;
        asserts++;
        if (rdt[1] !== 32'h0 || err[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_immediate: got rdt=%h err=%b rdy=%b required rdt=00000000 err=0 rdy=1",
                     rdt[1], err[1], rdy[1]);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            asserts++;
            if (rdt[1] !== 32'h0 || err[1] !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_stale: cycle %0d got rdt=%h err=%b required 00000000/0", c, rdt[1], err[1]);
            end
        end
        xfer(1, 1'b0, 32'h40, 4'h0, 32'h0);
        step();
        asserts++;
        if (rdt[1] !== 32'hA0) begin
            failures++; $display("FAIL rst_retained1: got %h required 000000a0", rdt[1]);
        end
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
        asserts++;
        if (rdt[0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rst_retained0: got %h required deadbeef", rdt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
